// File: rtl/conversor_bcd_sequencial.sv
// Signed binary to 4-digit BCD converter (double dabble, shift-and-add-3).
// Feeds the seven-segment display stage with sign, digit codes, the blank
// code (4'hA) for suppressed leading zeros and dashes (4'hF) on overflow.
// Fixed latency: start accepted at edge N, pronto pulses at edge N+16.
module conversor_bcd_sequencial #(
  parameter int LARGURA_ENTRADA = 32,
  parameter bit SUPRIMIR_ZEROS  = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic [LARGURA_ENTRADA-1:0] entrada,
  output logic                       ocupado,
  output logic                       pronto,
  output logic                       estouro,
  output logic                       sinal,
  output logic [3:0]                 milhar,
  output logic [3:0]                 centena,
  output logic [3:0]                 dezena,
  output logic [3:0]                 unidade
);

  localparam logic [3:0] COD_BRANCO = 4'b1010;
  localparam logic [3:0] COD_TRACO  = 4'b1111;
  localparam logic [3:0] ULTIMO_PASSO = 4'd13;

  typedef enum logic [1:0] {
    OCIOSO,
    PREPARA,
    CONVERTE,
    FORMATA
  } estado_t;

  estado_t estado_q, estado_d;

  logic [LARGURA_ENTRADA-1:0] entrada_q, entrada_d;
  logic [15:0]                bcd_q, bcd_d;
  logic [13:0]                bin_q, bin_d;
  logic [3:0]                 cont_q, cont_d;
  logic                       neg_q, neg_d;
  logic                       ovf_q, ovf_d;
  logic                       pronto_q, pronto_d;
  logic                       estouro_q, estouro_d;
  logic                       sinal_q, sinal_d;
  logic [3:0]                 milhar_q, milhar_d;
  logic [3:0]                 centena_q, centena_d;
  logic [3:0]                 dezena_q, dezena_d;
  logic [3:0]                 unidade_q, unidade_d;

  // One extra bit so that the most negative input has a representable magnitude.
  logic [LARGURA_ENTRADA:0] estendido;
  logic [LARGURA_ENTRADA:0] magnitude;

  // Add-3 correction of the BCD nibbles before the shift; the top nibble
  // keeps only the three bits that survive the shift.
  logic [11:0] bcd_baixo_aj;
  logic [2:0]  bcd_topo_aj;

  assign estendido = {entrada_q[LARGURA_ENTRADA-1], entrada_q};
  assign magnitude = estendido[LARGURA_ENTRADA]
                   ? (~estendido + (LARGURA_ENTRADA+1)'(1))
                   : estendido;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) estado_q <= OCIOSO;
    else       estado_q <= estado_d;
  end

  // Next-state logic: prepare, 14 conversion steps, format, back to idle.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:   if (iniciar) estado_d = PREPARA;
      PREPARA:  estado_d = CONVERTE;
      CONVERTE: if (cont_q == ULTIMO_PASSO) estado_d = FORMATA;
      FORMATA:  estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  // Add-3 step applied to every nibble >= 5.
  always_comb begin
    bcd_baixo_aj = bcd_q[11:0];
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_baixo_aj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (bcd_q[15:12] >= 4'd5) bcd_topo_aj = 3'(bcd_q[15:12] + 4'd3);
    else                      bcd_topo_aj = bcd_q[14:12];
  end

  // Datapath next values per state.
  always_comb begin
    entrada_d = entrada_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cont_d    = cont_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    pronto_d  = 1'b0;
    estouro_d = estouro_q;
    sinal_d   = sinal_q;
    milhar_d  = milhar_q;
    centena_d = centena_q;
    dezena_d  = dezena_q;
    unidade_d = unidade_q;
    case (estado_q)
      OCIOSO: begin
        if (iniciar) entrada_d = entrada;
      end
      PREPARA: begin
        neg_d  = entrada_q[LARGURA_ENTRADA-1] && (magnitude != '0);
        ovf_d  = magnitude > (LARGURA_ENTRADA+1)'(9999);
        bin_d  = magnitude[13:0];
        bcd_d  = '0;
        cont_d = '0;
      end
      CONVERTE: begin
        bcd_d  = {bcd_topo_aj, bcd_baixo_aj, bin_q[13]};
        bin_d  = {bin_q[12:0], 1'b0};
        cont_d = cont_q + 4'd1;
      end
      FORMATA: begin
        pronto_d = 1'b1;
        if (ovf_q) begin
          estouro_d = 1'b1;
          sinal_d   = 1'b0;
          milhar_d  = COD_TRACO;
          centena_d = COD_TRACO;
          dezena_d  = COD_TRACO;
          unidade_d = COD_TRACO;
        end else begin
          estouro_d = 1'b0;
          sinal_d   = neg_q;
          milhar_d  = bcd_q[15:12];
          centena_d = bcd_q[11:8];
          dezena_d  = bcd_q[7:4];
          unidade_d = bcd_q[3:0];
          if (SUPRIMIR_ZEROS) begin
            if (bcd_q[15:12] == 4'd0) milhar_d = COD_BRANCO;
            if (bcd_q[15:8] == 8'd0)  centena_d = COD_BRANCO;
            if (bcd_q[15:4] == 12'd0) dezena_d = COD_BRANCO;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      entrada_q <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      cont_q    <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      pronto_q  <= 1'b0;
      estouro_q <= 1'b0;
      sinal_q   <= 1'b0;
      milhar_q  <= '0;
      centena_q <= '0;
      dezena_q  <= '0;
      unidade_q <= '0;
    end else begin
      entrada_q <= entrada_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cont_q    <= cont_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      pronto_q  <= pronto_d;
      estouro_q <= estouro_d;
      sinal_q   <= sinal_d;
      milhar_q  <= milhar_d;
      centena_q <= centena_d;
      dezena_q  <= dezena_d;
      unidade_q <= unidade_d;
    end
  end

  assign ocupado = (estado_q != OCIOSO);
  assign pronto  = pronto_q;
  assign estouro = estouro_q;
  assign sinal   = sinal_q;
  assign milhar  = milhar_q;
  assign centena = centena_q;
  assign dezena  = dezena_q;
  assign unidade = unidade_q;

endmodule

// File: tb/tb_conversor_bcd_sequencial.sv
// Bench for conversor_bcd_sequencial: one instance with leading-zero
// suppression and one without, driven by the same stimulus.
module tb_conversor_bcd_sequencial;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic [31:0] entrada = '0;

  logic        ocupado, pronto, estouro, sinal;
  logic [3:0]  milhar, centena, dezena, unidade;
  logic        ocupado0, pronto0, estouro0, sinal0;
  logic [3:0]  milhar0, centena0, dezena0, unidade0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [17:0] sup;
    logic [17:0] nsup;
  } exp_t;

  exp_t sb[$];

  conversor_bcd_sequencial #(.LARGURA_ENTRADA(32), .SUPRIMIR_ZEROS(1'b1)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .entrada(entrada),
    .ocupado(ocupado), .pronto(pronto), .estouro(estouro), .sinal(sinal),
    .milhar(milhar), .centena(centena), .dezena(dezena), .unidade(unidade)
  );

  conversor_bcd_sequencial #(.LARGURA_ENTRADA(32), .SUPRIMIR_ZEROS(1'b0)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .entrada(entrada),
    .ocupado(ocupado0), .pronto(pronto0), .estouro(estouro0), .sinal(sinal0),
    .milhar(milhar0), .centena(centena0), .dezena(dezena0), .unidade(unidade0)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] model(input logic [31:0] v, input bit supr);
    longint s, mag;
    logic [3:0] m, c, d, u;
    logic sg;
    s   = longint'($signed(v));
    mag = (s < 0) ? -s : s;
    if (mag > 9999) return {1'b1, 1'b0, 16'hFFFF};
    m  = 4'(mag / 1000);
    c  = 4'((mag / 100) % 10);
    d  = 4'((mag / 10) % 10);
    u  = 4'(mag % 10);
    sg = (s < 0) && (mag != 0);
    if (supr && m == 4'd0) begin
      m = 4'hA;
      if (c == 4'd0) begin
        c = 4'hA;
        if (d == 4'd0) d = 4'hA;
      end
    end
    return {1'b0, sg, m, c, d, u};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] saida1();
    return {estouro, sinal, milhar, centena, dezena, unidade};
  endfunction

  function automatic logic [17:0] saida0();
    return {estouro0, sinal0, milhar0, centena0, dezena0, unidade0};
  endfunction

  task automatic compara_saida(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_vazio"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sup"}, 32'(saida1()), 32'(e.sup));
      chk({tag, "_nsup"}, 32'(saida0()), 32'(e.nsup));
    end
  endtask

  // Starts one conversion (DUT idle or in its pronto cycle), checks latency,
  // results, the single-cycle pronto and that outputs hold afterwards.
  task automatic converte(input string tag, input logic [31:0] v);
    exp_t e;
    int k;
    bit visto;
    logic [17:0] guardado;
    e.sup  = model(v, 1'b1);
    e.nsup = model(v, 1'b0);
    sb.push_back(e);
    iniciar = 1'b1;
    entrada = v;
    @(posedge clock); #1;
    iniciar = 1'b0;
    entrada = $urandom;
    visto = 1'b0;
    k = 0;
    while (!visto && k < 40) begin
      @(posedge clock); #1;
      k++;
      if (k == 1) chk({tag, "_ocupado"}, 32'(ocupado), 32'd1);
      if (pronto) visto = 1'b1;
    end
    if (!visto) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latencia"}, 32'(k), 32'd16);
      chk({tag, "_pronto0"}, 32'(pronto0), 32'd1);
      chk({tag, "_ocupado_fim"}, 32'(ocupado), 32'd0);
      compara_saida(tag);
      guardado = saida1();
      @(posedge clock); #1;
      chk({tag, "_pulso"}, 32'(pronto), 32'd0);
      chk({tag, "_mantem"}, 32'(saida1()), 32'(guardado));
    end
  endtask

  initial begin
    int pulsos, k, r;
    int bordas[$];
    exp_t e;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset_saidas", 32'({ocupado, pronto, saida1()}), 32'd0);
    chk("reset_saidas0", 32'({ocupado0, pronto0, saida0()}), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed values
    converte("v1234", 32'd1234);
    converte("vm56", -32'sd56);
    converte("v0", 32'd0);
    converte("v9999", 32'd9999);
    converte("vm9999", -32'sd9999);
    converte("v10000", 32'd10000);
    converte("vm10000", -32'sd10000);
    converte("vmin", 32'h8000_0000);
    converte("v100", 32'd100);
    converte("v5", 32'd5);
    converte("v16384", 32'd16384);

    // iniciar held high: second start accepted in the pronto cycle
    e.sup  = model(32'd7, 1'b1);
    e.nsup = model(32'd7, 1'b0);
    sb.push_back(e);
    sb.push_back(e);
    iniciar = 1'b1;
    entrada = 32'd7;
    @(posedge clock); #1;
    pulsos = 0;
    k = 0;
    while (pulsos < 2 && k < 60) begin
      @(posedge clock); #1;
      k++;
      if (pronto) begin
        pulsos++;
        bordas.push_back(k);
        compara_saida("b2b");
        if (pulsos == 2) iniciar = 1'b0;
      end
    end
    chk("b2b_pulsos", 32'(pulsos), 32'd2);
    if (bordas.size() == 2) begin
      chk("b2b_borda1", 32'(bordas[0]), 32'd16);
      chk("b2b_borda2", 32'(bordas[1]), 32'd33);
    end
    pulsos = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (pronto) pulsos++;
    end
    chk("b2b_sem_extra", 32'(pulsos), 32'd0);
    chk("b2b_ocioso", 32'(ocupado), 32'd0);

    // Reset in the middle of a conversion
    iniciar = 1'b1;
    entrada = 32'd4321;
    @(posedge clock); #1;
    iniciar = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_reset", 32'({ocupado, pronto, saida1()}), 32'd0);
    reset = 1'b0;
    pulsos = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (pronto) pulsos++;
    end
    chk("abort_sem_pronto", 32'(pulsos), 32'd0);
    chk("abort_saidas", 32'(saida1()), 32'd0);
    converte("v4321", 32'd4321);

    // Random values in [-12000, 12000]
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(24000)) - 12000;
      converte("aleat", 32'(r));
    end

    chk("sb_vazio", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
